pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register with valid/ready handshake, a 2-entry skid buffer, synchronous flush and saturating performance counters. It replaces the fixed-field, stall-vector-driven inter-stage registers (decode→execute and onward) with one reusable block: the payload is a flat bus, back-pressure is per-stage ready rather than a global stall vector, and bubbles are explicit through out_valid.

## Interface
- DATA_W, 330: payload width; the default is sized for the decode→execute bundle.
- SKID_EN, 1: 1 selects the 2-entry skid buffer with a registered in_ready; 0 selects a single register with a combinational in_ready.
- ZERO_BUBBLE, 1: 1 forces out_data to all-zero whenever out_valid=0, so zero is a NOP downstream.
- CNT_W, 16: width of each performance counter.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of all held entries, e.g. branch redirect.
- in_valid  in  1  upstream payload valid.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage can accept this cycle.
- out_valid  out  1  held payload valid.
- out_data  out  DATA_W  held payload.
- out_ready  in  1  downstream accepts this cycle.
- cnt_clr  in  1  synchronous clear of all counters.
- cnt_xfer  out  CNT_W  count of output handshakes.
- cnt_stall  out  CNT_W  count of cycles with out_valid & !out_ready.
- cnt_bubble  out  CNT_W  count of cycles with !out_valid & out_ready.

## Operation
- Accept = in_valid & in_ready & !flush. Emit = out_valid & out_ready.
- SKID_EN=1 state machine, with main register M and skid register S:
  - EMPTY: accept → FULL, M←in_data.
  - FULL: if accept & emit, stay FULL with M←in_data. If accept & !emit, go to SKID with S←in_data. If !accept & emit, go to EMPTY. Otherwise hold.
  - SKID: in_ready=0. If emit, go to FULL with M←S. Otherwise hold.
- in_ready is registered: in_ready = (state != SKID).
- SKID_EN=0: a single register M. in_ready = !out_valid | out_ready, combinational. Accept loads M. Emit without accept clears out_valid.
- out_valid = (state != EMPTY). out_data = M, or all-zero when ZERO_BUBBLE=1 and out_valid=0.
- Flush has priority over everything. The next state is EMPTY, the same-cycle in_data is dropped, and a same-cycle emit still completes downstream. S and M content is don't-care after flush; the zero-bubble masking still holds.
- Counters saturate at 2^CNT_W−1 and never wrap. cnt_clr has priority over the increment in the same cycle. Flush does not clear the counters.
- Payload order is strictly FIFO. No payload is duplicated or lost except by flush.

## Timing
- Reset (asynchronous) sets state EMPTY, out_valid=0, out_data=0, M=S=0, in_ready=1 and all counters 0. Reset mid-transfer discards the held entries with no partial output.
- Latency: in_data accepted at edge n appears on out_data after edge n, i.e. 1 cycle.
- Throughput: 1 transfer/cycle sustained when out_ready is held at 1.
- After out_ready drops, SKID_EN=1 absorbs exactly one more beat, then deasserts in_ready on the following cycle. in_ready returns to 1 one cycle after the SKID→FULL emit.
- Flush at edge n: out_valid=0 and in_ready=1 after edge n.
- Counters update on the same edge as the event they record.

## Structure
- Shared package pipe_pkg holds the state enum (EMPTY, FULL, SKID) and the default-width localparams for the decode→execute, execute→memory and memory→writeback bundles.
- One sub-module, sat_counter, instantiated three times. Parameter: W. Ports: clk, rst_n, clr, inc, cnt.
- Bundle pack/unpack stays with the instantiating stage, not in this block.

## Test plan
- Streaming: out_ready=1, in_valid=1 for 8 beats with data 1..8 → out_data 1..8 on consecutive cycles one cycle late, cnt_xfer=8, cnt_stall=0.
- Back-pressure: stream 1..4 and drop out_ready after beat 1 is shown → beat 2 lands in S, in_ready=0 the next cycle, and out_ready=1 releases 1,2,3,4 in order with none lost (SKID_EN=1).
- Flush in SKID state with in_valid=1 and data 0xAA → next cycle out_valid=0, out_data=0, in_ready=1, and 0xAA never appears.
- Bubble: in_valid=0 with out_ready=1 for 5 cycles → out_data=0, cnt_bubble=5. With ZERO_BUBBLE=0, out_data keeps its last value.
- Saturation: CNT_W=4 with 20 stall cycles → cnt_stall=15. Asserting cnt_clr and a stall in the same cycle → 0.
- Reset asserted mid-stream while in SKID state → all outputs take reset values immediately. After release, a stream of 1..3 passes cleanly. Repeat the full set with SKID_EN=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage state encoding and inter-stage bundle widths
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
  localparam int DEC_EX_W = 330;
  localparam int EX_MEM_W = 200;
  localparam int MEM_WB_W = 110;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready stage register with optional 2-entry skid buffer and saturating perf counters
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W      = DEC_EX_W,
  parameter bit SKID_EN     = 1'b1,
  parameter bit ZERO_BUBBLE = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_xfer,
  output logic [CNT_W-1:0]  cnt_stall,
  output logic [CNT_W-1:0]  cnt_bubble
);
  state_t            state, state_nxt;
  logic [DATA_W-1:0] m, s;
  logic              accept, emit;
  always_comb begin
    accept = in_valid & in_ready & !flush;
    emit   = out_valid & out_ready;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      m     <= '0;
      s     <= '0;
    end else begin
      state <= state_nxt;
      if (state == SKID && emit) m <= s;
      else if (accept && (state == EMPTY || emit)) m <= in_data;
      if (accept && state == FULL && !emit) s <= in_data;
    end
  // Without the skid buffer in_ready already blocks accept-without-emit in FULL, so SKID is never reached.
  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = EMPTY;
    else if (state == EMPTY) state_nxt = accept ? FULL : EMPTY;
    else if (state == FULL) state_nxt = (accept && !emit) ? SKID : (!accept && emit) ? EMPTY : FULL;
    else state_nxt = emit ? FULL : SKID;
  end
  always_comb begin
    out_valid = state != EMPTY;
    in_ready  = SKID_EN ? (state != SKID) : ((state == EMPTY) | out_ready);
    out_data  = (ZERO_BUBBLE && state == EMPTY) ? '0 : m;
  end
  sat_counter #(.W(CNT_W)) u_xfer (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(emit), .cnt(cnt_xfer)
  );
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(out_valid & !out_ready), .cnt(cnt_stall)
  );
  sat_counter #(.W(CNT_W)) u_bubble (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(!out_valid & out_ready), .cnt(cnt_bubble)
  );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: three stage variants (skid+zero, no-skid+zero, skid+hold) against a queue model
module tb_pipe_stage_skid;
  logic       clk, rst_n, flush, in_valid, out_ready, cnt_clr;
  logic [7:0] in_data;
  logic       ir[3], ov[3];
  logic [7:0] od[3];
  logic [3:0] cx[3], cs[3], cb[3];
  int         checks, errors;

  initial clk = 0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipe_stage_skid #(.DATA_W(8), .SKID_EN(g != 1), .ZERO_BUBBLE(g != 2), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(ir[g]), .out_valid(ov[g]), .out_data(od[g]), .out_ready(out_ready),
      .cnt_clr(cnt_clr), .cnt_xfer(cx[g]), .cnt_stall(cs[g]), .cnt_bubble(cb[g])
    );
  end

  // behavioural model: per instance an ordered list of held beats (capacity 2 with skid, else 1)
  logic [7:0] mq[3][2];
  int         mn[3], mx[3], ms[3], mb[3];
  logic [7:0] hold[3];
  bit         hold_ok[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_rdy(int k);
    return (k != 1) ? (mn[k] != 2) : (mn[k] == 0 || out_ready);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mn[k] = 0; mx[k] = 0; ms[k] = 0; mb[k] = 0; hold[k] = 0; hold_ok[k] = 1;
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("valid%0d", k), ov[k], mn[k] > 0);
      if (mn[k] > 0) chk($sformatf("data%0d", k), od[k], mq[k][0]);
      else if (k != 2) chk($sformatf("zero%0d", k), od[k], 0);
      else if (hold_ok[k]) chk($sformatf("hold%0d", k), od[k], hold[k]);
      chk($sformatf("ready%0d", k), ir[k], model_rdy(k));
      chk($sformatf("xfer%0d", k), cx[k], mx[k]);
      chk($sformatf("stall%0d", k), cs[k], ms[k]);
      chk($sformatf("bubble%0d", k), cb[k], mb[k]);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit em, acc;
      em  = mn[k] > 0 && out_ready;
      acc = in_valid && model_rdy(k) && !flush;
      if (cnt_clr) begin
        mx[k] = 0; ms[k] = 0; mb[k] = 0;
      end else begin
        if (em && mx[k] < 15) mx[k]++;
        if (mn[k] > 0 && !out_ready && ms[k] < 15) ms[k]++;
        if (mn[k] == 0 && out_ready && mb[k] < 15) mb[k]++;
      end
      if (flush) begin
        mn[k] = 0; hold_ok[k] = 0;
      end else begin
        if (em) begin
          hold[k] = mq[k][0]; mq[k][0] = mq[k][1]; mn[k]--; hold_ok[k] = 1;
        end
        if (acc) begin
          mq[k][mn[k]] = in_data; mn[k]++;
        end
      end
    end
  endtask

  task automatic pre();
    @(negedge clk);
    model_check();
  endtask

  task automatic post();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drv(input logic iv, input logic [7:0] d, input logic ordy,
                     input logic fl = 0, input logic clr = 0);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; cnt_clr = clr;
    pre();
    post();
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_valid%0d", tag, k), ov[k], 0);
      chk($sformatf("%s_data%0d", tag, k), od[k], 0);
      chk($sformatf("%s_ready%0d", tag, k), ir[k], 1);
      chk($sformatf("%s_cnt%0d", tag, k), {cx[k], cs[k], cb[k]}, 0);
    end
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       ev;
    logic [7:0] ed;
    logic       er;
  } vec_t;
  vec_t tbl[18];

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0;
    rst_n = 0; in_valid = 0; in_data = 0; out_ready = 0; flush = 0; cnt_clr = 0;
    for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 8'(i + 1), 1'b1, i > 0, 8'(i), 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h08, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[10] = '{1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[11] = '{1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b1};
    tbl[12] = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 1'b0};
    tbl[13] = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h01, 1'b0};
    tbl[14] = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1};
    tbl[15] = '{1'b1, 8'h04, 1'b1, 1'b1, 8'h03, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
    #2;
    check_reset("rst");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    // streaming then back-pressure on the skid instance
    for (int i = 0; i < 18; i++) begin
      in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      pre();
      chk($sformatf("tbl%0d_valid", i), ov[0], tbl[i].ev);
      chk($sformatf("tbl%0d_data", i), od[0], tbl[i].ed);
      chk($sformatf("tbl%0d_ready", i), ir[0], tbl[i].er);
      post();
    end
    chk("tbl_xfer", cx[0], 12);
    chk("tbl_stall", cs[0], 2);
    chk("tbl_bubble", cb[0], 4);
    // flush while holding two beats
    drv(1, 8'h11, 0);
    drv(1, 8'h22, 0);
    chk("skid_ready", ir[0], 0);
    drv(1, 8'hAA, 0, 1);
    chk("flush_valid", ov[0], 0);
    chk("flush_data", od[0], 0);
    chk("flush_ready", ir[0], 1);
    for (int i = 0; i < 3; i++) begin
      drv(0, 8'h00, 1);
      chk($sformatf("post_flush_data%0d", i), od[0], 0);
    end
    // bubbles with zero masking vs hold
    drv(1, 8'h5C, 1);
    drv(0, 8'h00, 1, 0, 1);
    for (int i = 0; i < 5; i++) drv(0, 8'h00, 1);
    chk("bubble_cnt", cb[0], 5);
    chk("bubble_zero", od[0], 0);
    chk("bubble_hold", od[2], 8'h5C);
    // saturation and clear-beats-increment
    drv(1, 8'h33, 0, 0, 1);
    for (int i = 0; i < 20; i++) drv(0, 8'h00, 0);
    chk("stall_sat", cs[0], 15);
    chk("stall_sat_noskid", cs[1], 15);
    drv(0, 8'h00, 0, 0, 1);
    chk("stall_clr", cs[0], 0);
    // asynchronous reset while in SKID
    drv(1, 8'h44, 0);
    chk("pre_rst_ready", ir[0], 0);
    in_valid = 0; out_ready = 0;
    rst_n = 0;
    #1;
    check_reset("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 3; i++) drv(1, 8'(i), 1);
    drv(0, 8'h00, 1);
    drv(0, 8'h00, 1);
    chk("rst_stream_xfer", cx[0], 3);
    chk("rst_stream_xfer_noskid", cx[1], 3);
    // random traffic against the model
    for (int i = 0; i < 400; i++)
      drv($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
          $urandom_range(0, 29) == 0, $urandom_range(0, 49) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
